// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single complete-stage PR write port and CDB broadcast.
// One winner per cycle is registered into a one-entry output stage.
module cdb_arbiter #(
   parameter int NUM_REQ  = 5,
   parameter int PR_IDX_W = 6,
   parameter int ZERO_PR  = 31
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               en,
   input  logic                               rollback,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ-1:0][PR_IDX_W-1:0]   req_T_idx,
   input  logic [NUM_REQ-1:0][63:0]           req_T_value,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic                               write_en,
   output logic [PR_IDX_W-1:0]                T_idx,
   output logic [63:0]                        T_value
);
   localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PR_IDX_W-1:0] ZERO_IDX = PR_IDX_W'(ZERO_PR);
   localparam logic [RR_W-1:0]     LAST_FU  = RR_W'(NUM_REQ - 1);

   logic [RR_W-1:0]    rr;
   logic [RR_W-1:0]    rr_next;
   logic [RR_W-1:0]    winner;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] drain;
   logic               found;
   logic               open;
   logic               accept;

   // Any cycle that can accept anything: reset and rollback both block all handshakes.
   assign open = en && !rollback && !reset;

   always_comb begin
      eligible = '0;
      drain    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] && (req_T_idx[i] != ZERO_IDX);
         drain[i]    = req_valid[i] && (req_T_idx[i] == ZERO_IDX);
      end
   end

   always_comb begin : rr_scan
      int              j;
      logic [RR_W-1:0] pos;
      found  = 1'b0;
      winner = '0;
      j      = 0;
      pos    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(rr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         pos = RR_W'(j);
         if (!found && eligible[pos]) begin
            found  = 1'b1;
            winner = pos;
         end
      end
   end

   assign accept  = found && open;
   assign rr_next = (winner == LAST_FU) ? '0 : winner + 1'b1;

   // Zero-PR results are dropped on the floor without touching the pointer.
   always_comb begin
      req_ready = '0;
      if (open) req_ready = drain;
      if (accept) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr       <= '0;
         write_en <= 1'b0;
         T_idx    <= '0;
         T_value  <= '0;
      end else if (rollback) begin
         rr       <= '0;
         write_en <= 1'b0;
      end else if (en) begin
         write_en <= accept;
         if (accept) begin
            rr      <= rr_next;
            T_idx   <= req_T_idx[winner];
            T_value <= req_T_value[winner];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; accepted payloads go into a scoreboard queue
// and are popped when the output stage should present them.
module tb_cdb_arbiter;
   localparam int N  = 5;
   localparam int IW = 6;
   localparam int Z  = 31;

   logic                  clock;
   logic                  reset;
   logic                  en;
   logic                  rollback;
   logic [N-1:0]          req_valid;
   logic [N-1:0][IW-1:0]  req_T_idx;
   logic [N-1:0][63:0]    req_T_value;
   logic [N-1:0]          req_ready;
   logic                  write_en;
   logic [IW-1:0]         T_idx;
   logic [63:0]           T_value;

   int                    total = 0;
   int                    bad   = 0;
   logic [IW+63:0]        sb_q[$];
   logic [IW+63:0]        cur = '0;

   cdb_arbiter #(.NUM_REQ(N), .PR_IDX_W(IW), .ZERO_PR(Z)) dut (
      .clock       (clock),
      .reset       (reset),
      .en          (en),
      .rollback    (rollback),
      .req_valid   (req_valid),
      .req_T_idx   (req_T_idx),
      .req_T_value (req_T_value),
      .req_ready   (req_ready),
      .write_en    (write_en),
      .T_idx       (T_idx),
      .T_value     (T_value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rq(input int i, input int idx, input logic [63:0] val);
      req_valid[i]   = 1'b1;
      req_T_idx[i]   = IW'(idx);
      req_T_value[i] = val;
   endtask

   // Called just after a negedge with inputs set: checks ready, records accepted
   // payloads, runs one clock, then checks the output stage.
   task automatic step(input logic [N-1:0] exp_rdy, input logic exp_we, input string tag);
      logic pushed;
      pushed = 1'b0;
      #1;
      chk({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < N; i++) begin
         if (exp_rdy[i] && (req_T_idx[i] != IW'(Z))) begin
            sb_q.push_back({req_T_idx[i], req_T_value[i]});
            pushed = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++)
         if (exp_rdy[i]) req_valid[i] = 1'b0;
      if (pushed && sb_q.size() > 0) cur = sb_q.pop_front();
      chk({tag, ".write_en"}, 64'(write_en), 64'(exp_we));
      if (exp_we) begin
         chk({tag, ".T_idx"}, 64'(T_idx), 64'(cur[IW+63:64]));
         chk({tag, ".T_value"}, T_value, cur[63:0]);
      end
      @(negedge clock);
   endtask

   initial begin
      reset       = 1'b1;
      en          = 1'b1;
      rollback    = 1'b0;
      req_valid   = '0;
      req_T_idx   = '0;
      req_T_value = '0;

      rq(0, 3, 64'h33);
      #1;
      chk("reset.ready", 64'(req_ready), 64'h0);
      repeat (2) @(posedge clock);
      #1;
      chk("reset.write_en", 64'(write_en), 64'h0);
      chk("reset.T_idx", 64'(T_idx), 64'h0);
      chk("reset.T_value", T_value, 64'h0);
      @(negedge clock);
      reset     = 1'b0;
      req_valid = '0;

      // single request, then idle
      rq(2, 5, 64'hDEAD);
      step(5'b00100, 1'b1, "single");
      step(5'b00000, 1'b0, "single_idle");
      // pointer now 3: FU4 beats FU1
      rq(1, 8, 64'h81);
      rq(4, 11, 64'hB4);
      step(5'b10000, 1'b1, "rr3_fu4");
      step(5'b00010, 1'b1, "rr3_fu1");

      // rollback with nothing pending returns the pointer to 0
      rollback = 1'b1;
      step(5'b00000, 1'b0, "rb_idle");
      rollback = 1'b0;

      // all FUs requesting continuously
      for (int i = 0; i < N; i++) rq(i, i + 1, 64'h1000 + 64'(i));
      for (int k = 0; k < 6; k++) begin
         int w;
         w = k % N;
         step(N'(1) << w, 1'b1, $sformatf("fair%0d", k));
         rq(w, w + 1, 64'h2000 + 64'(k));
      end
      req_valid = '0;
      step(5'b00000, 1'b0, "fair_idle");

      // pointer to 4, then wrap past 4 to FU1, then FU3
      rq(3, 14, 64'h300);
      step(5'b01000, 1'b1, "set_rr4");
      rq(1, 15, 64'h301);
      rq(3, 16, 64'h302);
      step(5'b00010, 1'b1, "wrap_fu1");
      step(5'b01000, 1'b1, "wrap_fu3");
      rq(0, 17, 64'h303);
      rq(4, 18, 64'h304);
      step(5'b10000, 1'b1, "rr4_fu4");
      step(5'b00001, 1'b1, "rr4_fu0");

      // zero-PR drain alongside a real grant
      rq(0, Z, 64'hBAD0);
      rq(1, 7, 64'h777);
      step(5'b00011, 1'b1, "zero_drain");
      rq(1, 19, 64'h401);
      rq(2, 20, 64'h402);
      step(5'b00100, 1'b1, "rr2_fu2");
      step(5'b00010, 1'b1, "rr2_fu1");

      // stall holds the output and blocks all handshakes
      rq(0, 9, 64'h999);
      step(5'b00001, 1'b1, "stall_grant");
      en = 1'b0;
      rq(1, 10, 64'hAAA);
      rq(2, Z, 64'hBAD2);
      for (int s = 0; s < 3; s++) step(5'b00000, 1'b1, $sformatf("stall%0d", s));
      en = 1'b1;
      step(5'b00110, 1'b1, "stall_release");

      // rollback the cycle after a grant
      rq(3, 12, 64'hC12);
      step(5'b01000, 1'b1, "rb_grant");
      rollback = 1'b1;
      rq(4, 13, 64'hD13);
      rq(0, Z, 64'hBAD3);
      step(5'b00000, 1'b0, "rb_squash");
      rollback = 1'b0;
      step(5'b10001, 1'b1, "rb_after");
      rq(0, 2, 64'h502);
      rq(4, 3, 64'h503);
      step(5'b00001, 1'b1, "rb_rr0_fu0");
      step(5'b10000, 1'b1, "rb_rr0_fu4");

      // rollback overrides a stall
      rq(1, 24, 64'h601);
      step(5'b00010, 1'b1, "rbst_grant");
      en       = 1'b0;
      rollback = 1'b1;
      rq(2, 25, 64'h602);
      step(5'b00000, 1'b0, "rbst_squash");
      en       = 1'b1;
      rollback = 1'b0;
      step(5'b00100, 1'b1, "rbst_after");

      // reset mid-operation
      rq(2, 21, 64'h701);
      step(5'b00100, 1'b1, "rst_grant");
      reset = 1'b1;
      rq(3, 22, 64'h702);
      step(5'b00000, 1'b0, "rst_mid");
      chk("rst_mid.T_idx", 64'(T_idx), 64'h0);
      chk("rst_mid.T_value", T_value, 64'h0);
      reset = 1'b0;
      step(5'b01000, 1'b1, "rst_after");
      step(5'b00000, 1'b0, "final_idle");

      chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
